// File: rtl/fewcore_hazard_pkg.sv
// fewcore_hazard_pkg: shared types and constants for the fewcore hazard controller.
//   hazard_state_t  sequencer states (RUN / LOAD_STALL / FLUSH / MEM_WAIT)
//   FWD_*           2-bit operand-forwarding select encodings
//   max3            helper used to size the shared stall/flush/wait counter
package fewcore_hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2,
        MEM_WAIT   = 2'd3
    } hazard_state_t;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hazard_controller_if.sv
// hazard_controller_if: bundle between the fewcore pipeline and its hazard controller.
//   slave  modport: the hazard controller (reads pipeline status, drives control)
//   master modport: the pipeline side (drives status, reads control)
//   Status : id_rs1/id_rs2/id_uses_rs1/id_uses_rs2, ex_rd/ex_reg_write/ex_is_load,
//            mem_rd/mem_reg_write, branch_taken, dmem_req/dmem_ack
//   Control: pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pipe_freeze,
//            fwd_rs1/fwd_rs2, mem_error
interface hazard_controller_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_is_load;
    logic [4:0] mem_rd;
    logic       mem_reg_write;
    logic       branch_taken;
    logic       dmem_req;
    logic       dmem_ack;

    logic       pc_stall;
    logic       if_id_stall;
    logic       id_ex_bubble;
    logic       if_id_flush;
    logic       pipe_freeze;
    logic [1:0] fwd_rs1;
    logic [1:0] fwd_rs2;
    logic       mem_error;

    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        input  ex_rd, ex_reg_write, ex_is_load,
        input  mem_rd, mem_reg_write,
        input  branch_taken, dmem_req, dmem_ack,
        output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pipe_freeze,
        output fwd_rs1, fwd_rs2, mem_error
    );

    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
        output ex_rd, ex_reg_write, ex_is_load,
        output mem_rd, mem_reg_write,
        output branch_taken, dmem_req, dmem_ack,
        input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pipe_freeze,
        input  fwd_rs1, fwd_rs2, mem_error
    );

endinterface

// File: rtl/fwd_select.sv
// fwd_select: forwarding source for one ALU operand (purely combinational).
//   rs                           source register of the operand
//   ex_rd/ex_reg_write           destination of the instruction one stage ahead
//   mem_rd/mem_reg_write         destination of the instruction two stages ahead
//   sel                          FWD_EXMEM, else FWD_MEMWB, else FWD_REGFILE
// The younger (EX) result wins when both stages match; x0 is never forwarded.
module fwd_select
    import fewcore_hazard_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REGFILE;
        if (ex_reg_write && (ex_rd != '0) && (ex_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (mem_reg_write && (mem_rd != '0) && (mem_rd == rs)) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencer for the fewcore 5-stage integer pipeline.
//   clk    single clock, rising edge
//   reset  synchronous, active-high; gates every output to 0 while asserted
//   hz     slave side of hazard_controller_if (pipeline status in, stall/flush/
//          freeze/forwarding controls and sticky mem_error out)
// Outputs are Mealy: decoded from the current state and current inputs.
// Priority in RUN: memory wait > taken branch > load-use.
module hazard_controller
    import fewcore_hazard_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned BRANCH_PENALTY    = 2,
    parameter int unsigned MEM_TIMEOUT       = 255
) (
    input  logic                clk,
    input  logic                reset,
    hazard_controller_if.slave  hz
);

    localparam int unsigned CW = $clog2(max3(LOAD_STALL_CYCLES, BRANCH_PENALTY, MEM_TIMEOUT) + 1);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t LS_LAST  = cnt_t'(LOAD_STALL_CYCLES - 1);
    localparam cnt_t BR_LAST  = cnt_t'(BRANCH_PENALTY - 1);
    localparam cnt_t TIMEOUT  = cnt_t'(MEM_TIMEOUT);
    localparam cnt_t CNT_MAX  = '1;
    localparam cnt_t CNT_ONE  = cnt_t'(1);

    hazard_state_t state, state_n;
    cnt_t          cnt, cnt_n;
    logic          mem_error_q, mem_error_n;

    logic mem_wait, load_use;
    logic stall_c, bubble_c, flush_c, freeze_c;
    logic [1:0] sel_rs1, sel_rs2;

    assign mem_wait = hz.dmem_req & ~hz.dmem_ack;
    assign load_use = hz.ex_is_load & hz.ex_reg_write & (hz.ex_rd != '0) &
                      ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
                       (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        mem_error_n = mem_error_q;
        stall_c     = 1'b0;
        bubble_c    = 1'b0;
        flush_c     = 1'b0;
        freeze_c    = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_wait) begin
                    freeze_c = 1'b1;
                    stall_c  = 1'b1;
                    state_n  = MEM_WAIT;
                    cnt_n    = CNT_ONE;
                end else if (hz.branch_taken) begin
                    // a simultaneous load-use is dropped: its instruction is being killed
                    flush_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (BRANCH_PENALTY > 1) begin
                        state_n = FLUSH;
                        cnt_n   = CNT_ONE;
                    end
                end else if (load_use) begin
                    stall_c  = 1'b1;
                    bubble_c = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_n = LOAD_STALL;
                        cnt_n   = CNT_ONE;
                    end
                end
            end
            LOAD_STALL, FLUSH: begin
                if (mem_wait) begin
                    freeze_c = 1'b1;
                    stall_c  = 1'b1;
                    state_n  = MEM_WAIT;
                    cnt_n    = CNT_ONE;
                end else begin
                    bubble_c = 1'b1;
                    if (state == LOAD_STALL) stall_c = 1'b1;
                    else                     flush_c = 1'b1;
                    if (cnt == ((state == LOAD_STALL) ? LS_LAST : BR_LAST)) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_ONE;
                    end
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ack) begin
                    state_n = RUN;
                    cnt_n   = '0;
                end else begin
                    freeze_c = 1'b1;
                    stall_c  = 1'b1;
                    if (cnt != CNT_MAX) cnt_n = cnt + CNT_ONE;
                end
            end
            default: begin
                state_n = RUN;
                cnt_n   = '0;
            end
        endcase
        // error is raised on the same edge that brings the wait count to the limit
        if ((state_n == MEM_WAIT) && (cnt_n >= TIMEOUT)) mem_error_n = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= '0;
            mem_error_q <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            mem_error_q <= mem_error_n;
        end
    end

    fwd_select u_fwd_rs1 (
        .rs            (hz.id_rs1),
        .ex_rd         (hz.ex_rd),
        .ex_reg_write  (hz.ex_reg_write),
        .mem_rd        (hz.mem_rd),
        .mem_reg_write (hz.mem_reg_write),
        .sel           (sel_rs1)
    );

    fwd_select u_fwd_rs2 (
        .rs            (hz.id_rs2),
        .ex_rd         (hz.ex_rd),
        .ex_reg_write  (hz.ex_reg_write),
        .mem_rd        (hz.mem_rd),
        .mem_reg_write (hz.mem_reg_write),
        .sel           (sel_rs2)
    );

    assign hz.pc_stall     = stall_c  & ~reset;
    assign hz.if_id_stall  = stall_c  & ~reset;
    assign hz.id_ex_bubble = bubble_c & ~reset;
    assign hz.if_id_flush  = flush_c  & ~reset;
    assign hz.pipe_freeze  = freeze_c & ~reset;
    assign hz.fwd_rs1      = (reset | freeze_c) ? FWD_REGFILE : sel_rs1;
    assign hz.fwd_rs2      = (reset | freeze_c) ? FWD_REGFILE : sel_rs2;
    assign hz.mem_error    = mem_error_q & ~reset;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed checks of hazard_controller.
// dut_a uses default parameters (1/2/255); dut_b uses 3/3/4 so multi-cycle stalls,
// flushes and the timeout are visible in short sequences. Both see identical stimulus.
module tb_hazard_controller;

    logic clk;
    logic reset;

    hazard_controller_if ifa ();
    hazard_controller_if ifb ();

    hazard_controller dut_a (
        .clk   (clk),
        .reset (reset),
        .hz    (ifa.slave)
    );

    hazard_controller #(
        .LOAD_STALL_CYCLES (3),
        .BRANCH_PENALTY    (3),
        .MEM_TIMEOUT       (4)
    ) dut_b (
        .clk   (clk),
        .reset (reset),
        .hz    (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, pipe_freeze}
    localparam logic [4:0] C_NONE  = 5'b00000;
    localparam logic [4:0] C_STALL = 5'b11100;
    localparam logic [4:0] C_FLUSH = 5'b00110;
    localparam logic [4:0] C_FRZ   = 5'b11001;

    logic [4:0] ctrl_a, ctrl_b;
    assign ctrl_a = {ifa.pc_stall, ifa.if_id_stall, ifa.id_ex_bubble, ifa.if_id_flush, ifa.pipe_freeze};
    assign ctrl_b = {ifb.pc_stall, ifb.if_id_stall, ifb.id_ex_bubble, ifb.if_id_flush, ifb.pipe_freeze};

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] ex_rd;
        logic       ex_w, ex_ld;
        logic [4:0] mem_rd;
        logic       mem_w, br, req, ack;
        logic [4:0] ctrl;
        logic [1:0] f1, f2;
    } vec_t;

    int checks = 0;
    int errors = 0;

    function automatic vec_t mk(string n, logic [4:0] rs1, logic [4:0] rs2, logic u1, logic u2,
                                logic [4:0] ex_rd, logic ex_w, logic ex_ld,
                                logic [4:0] mem_rd, logic mem_w, logic br, logic req, logic ack,
                                logic [4:0] ctrl, logic [1:0] f1, logic [1:0] f2);
        vec_t v;
        v.name = n; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.ex_rd = ex_rd; v.ex_w = ex_w; v.ex_ld = ex_ld;
        v.mem_rd = mem_rd; v.mem_w = mem_w; v.br = br; v.req = req; v.ack = ack;
        v.ctrl = ctrl; v.f1 = f1; v.f2 = f2;
        return v;
    endfunction

    task automatic set_in(input vec_t v);
        ifa.id_rs1 = v.rs1;   ifb.id_rs1 = v.rs1;
        ifa.id_rs2 = v.rs2;   ifb.id_rs2 = v.rs2;
        ifa.id_uses_rs1 = v.u1; ifb.id_uses_rs1 = v.u1;
        ifa.id_uses_rs2 = v.u2; ifb.id_uses_rs2 = v.u2;
        ifa.ex_rd = v.ex_rd;  ifb.ex_rd = v.ex_rd;
        ifa.ex_reg_write = v.ex_w; ifb.ex_reg_write = v.ex_w;
        ifa.ex_is_load = v.ex_ld;  ifb.ex_is_load = v.ex_ld;
        ifa.mem_rd = v.mem_rd; ifb.mem_rd = v.mem_rd;
        ifa.mem_reg_write = v.mem_w; ifb.mem_reg_write = v.mem_w;
        ifa.branch_taken = v.br; ifb.branch_taken = v.br;
        ifa.dmem_req = v.req; ifb.dmem_req = v.req;
        ifa.dmem_ack = v.ack; ifb.dmem_ack = v.ack;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    vec_t v_idle, v_lu, v_br, v_brlu, v_wait, v_ack;

    task automatic do_reset();
        reset = 1'b1;
        set_in(v_idle);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // apply one cycle of stimulus (entered at posedge+1), check both DUTs mid-cycle
    task automatic cyc(input string nm, input vec_t v, input logic [4:0] ea, input logic [4:0] eb,
                       input logic erra, input logic errb);
        set_in(v);
        #3;
        chk({nm, "_ctrl_a"}, {3'b0, ctrl_a}, {3'b0, ea});
        chk({nm, "_ctrl_b"}, {3'b0, ctrl_b}, {3'b0, eb});
        chk({nm, "_err_a"}, {7'b0, ifa.mem_error}, {7'b0, erra});
        chk({nm, "_err_b"}, {7'b0, ifb.mem_error}, {7'b0, errb});
        @(posedge clk); #1;
    endtask

    vec_t vecs[17];

    initial begin
        v_idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00);
        v_lu   = mk("lu",   5, 1, 1, 0, 5, 1, 1, 0, 0, 0, 0, 0, C_NONE, 2'b00, 2'b00);
        v_br   = mk("br",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, C_NONE, 2'b00, 2'b00);
        v_brlu = mk("brlu", 5, 1, 1, 0, 5, 1, 1, 0, 0, 1, 0, 0, C_NONE, 2'b00, 2'b00);
        v_wait = mk("wait", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_NONE, 2'b00, 2'b00);
        v_ack  = mk("ack",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, 2'b00, 2'b00);

        //               name              rs1 rs2 u1 u2 exrd exw ld memrd mw br rq ak  ctrl     f1     f2
        vecs[0]  = mk("x0_load_nofwd",     0,  0, 1, 1,  0,  1, 1,  0,  1, 0, 0, 0, C_NONE,  2'b00, 2'b00);
        vecs[1]  = mk("lu_rs1",            5,  1, 1, 0,  5,  1, 1,  0,  0, 0, 0, 0, C_STALL, 2'b01, 2'b00);
        vecs[2]  = mk("lu_rs2",            3,  9, 0, 1,  9,  1, 1,  0,  0, 0, 0, 0, C_STALL, 2'b00, 2'b01);
        vecs[3]  = mk("load_rs_unused",    5,  1, 0, 1,  5,  1, 1,  0,  0, 0, 0, 0, C_NONE,  2'b01, 2'b00);
        vecs[4]  = mk("load_no_wr",        5,  0, 1, 0,  5,  0, 1,  0,  0, 0, 0, 0, C_NONE,  2'b00, 2'b00);
        vecs[5]  = mk("alu_no_stall",      5,  0, 1, 0,  5,  1, 0,  0,  0, 0, 0, 0, C_NONE,  2'b01, 2'b00);
        vecs[6]  = mk("fwd_ex_pri",        0,  7, 0, 1,  7,  1, 0,  7,  1, 0, 0, 0, C_NONE,  2'b00, 2'b01);
        vecs[7]  = mk("fwd_mem",           0,  7, 0, 1,  7,  0, 0,  7,  1, 0, 0, 0, C_NONE,  2'b00, 2'b10);
        vecs[8]  = mk("fwd_split",        12,  3, 1, 1,  3,  1, 0, 12,  1, 0, 0, 0, C_NONE,  2'b10, 2'b01);
        vecs[9]  = mk("branch",            0,  0, 0, 0,  0,  0, 0,  0,  0, 1, 0, 0, C_FLUSH, 2'b00, 2'b00);
        vecs[10] = mk("branch_over_lu",    5,  0, 1, 0,  5,  1, 1,  0,  0, 1, 0, 0, C_FLUSH, 2'b01, 2'b00);
        vecs[11] = mk("wait_fwd_gated",    7,  7, 1, 1,  7,  1, 0,  7,  1, 0, 1, 0, C_FRZ,   2'b00, 2'b00);
        vecs[12] = mk("wait_over_all",     5,  0, 1, 0,  5,  1, 1,  0,  0, 1, 1, 0, C_FRZ,   2'b00, 2'b00);
        vecs[13] = mk("req_acked",         4,  0, 1, 0,  4,  1, 0,  0,  0, 0, 1, 1, C_NONE,  2'b01, 2'b00);
        vecs[14] = mk("acked_branch",      0,  0, 0, 0,  0,  0, 0,  0,  0, 1, 1, 1, C_FLUSH, 2'b00, 2'b00);
        vecs[15] = mk("mem_x0",            0,  0, 1, 1,  0,  0, 0,  0,  1, 0, 0, 0, C_NONE,  2'b00, 2'b00);
        vecs[16] = mk("ack_no_req_lu",     5,  1, 1, 0,  5,  1, 1,  0,  0, 0, 0, 1, C_STALL, 2'b01, 2'b00);

        // outputs gated while reset is held, even with every hazard input active
        reset = 1'b1;
        set_in(mk("all", 7, 7, 1, 1, 7, 1, 1, 7, 1, 1, 1, 0, C_NONE, 2'b00, 2'b00));
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("rst_ctrl_a", {3'b0, ctrl_a}, 8'd0);
        chk("rst_ctrl_b", {3'b0, ctrl_b}, 8'd0);
        chk("rst_fwd_a", {4'b0, ifa.fwd_rs1, ifa.fwd_rs2}, 8'd0);
        chk("rst_err_a", {7'b0, ifa.mem_error}, 8'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // single-cycle decode table, each vector from a fresh RUN state
        for (int i = 0; i < 17; i++) begin
            do_reset();
            set_in(vecs[i]);
            #3;
            chk({vecs[i].name, "_ctrl_a"}, {3'b0, ctrl_a}, {3'b0, vecs[i].ctrl});
            chk({vecs[i].name, "_ctrl_b"}, {3'b0, ctrl_b}, {3'b0, vecs[i].ctrl});
            chk({vecs[i].name, "_fwd1_a"}, {6'b0, ifa.fwd_rs1}, {6'b0, vecs[i].f1});
            chk({vecs[i].name, "_fwd2_a"}, {6'b0, ifa.fwd_rs2}, {6'b0, vecs[i].f2});
            chk({vecs[i].name, "_fwd2_b"}, {6'b0, ifb.fwd_rs2}, {6'b0, vecs[i].f2});
            @(posedge clk); #1;
        end

        // load-use: 1 stall cycle (a) vs 3 (b)
        do_reset();
        cyc("lu_c1", v_lu,   C_STALL, C_STALL, 0, 0);
        cyc("lu_c2", v_idle, C_NONE,  C_STALL, 0, 0);
        cyc("lu_c3", v_idle, C_NONE,  C_STALL, 0, 0);
        cyc("lu_c4", v_idle, C_NONE,  C_NONE,  0, 0);

        // taken branch: 2 flush cycles (a) vs 3 (b)
        do_reset();
        cyc("br_c1", v_br,   C_FLUSH, C_FLUSH, 0, 0);
        cyc("br_c2", v_idle, C_FLUSH, C_FLUSH, 0, 0);
        cyc("br_c3", v_idle, C_NONE,  C_FLUSH, 0, 0);
        cyc("br_c4", v_idle, C_NONE,  C_NONE,  0, 0);

        // branch with load-use: the load-use never stalls
        do_reset();
        cyc("brlu_c1", v_brlu, C_FLUSH, C_FLUSH, 0, 0);
        cyc("brlu_c2", v_lu,   C_FLUSH, C_FLUSH, 0, 0);
        cyc("brlu_c3", v_idle, C_NONE,  C_FLUSH, 0, 0);
        cyc("brlu_c4", v_idle, C_NONE,  C_NONE,  0, 0);

        // memory wait 4 cycles; dut_b reaches its timeout of 4 on the 4th wait edge
        do_reset();
        cyc("mw_c1", v_wait, C_FRZ,  C_FRZ,  0, 0);
        cyc("mw_c2", v_wait, C_FRZ,  C_FRZ,  0, 0);
        cyc("mw_c3", v_wait, C_FRZ,  C_FRZ,  0, 0);
        cyc("mw_c4", v_wait, C_FRZ,  C_FRZ,  0, 0);
        cyc("mw_c5", v_ack,  C_NONE, C_NONE, 0, 1);
        cyc("mw_c6", v_idle, C_NONE, C_NONE, 0, 1);
        do_reset();
        cyc("mw_rst", v_idle, C_NONE, C_NONE, 0, 0);

        // memory wait preempts FLUSH
        do_reset();
        cyc("fp_c1", v_br,   C_FLUSH, C_FLUSH, 0, 0);
        cyc("fp_c2", v_wait, C_FRZ,   C_FRZ,   0, 0);
        cyc("fp_c3", v_wait, C_FRZ,   C_FRZ,   0, 0);
        cyc("fp_c4", v_ack,  C_NONE,  C_NONE,  0, 0);
        cyc("fp_c5", v_idle, C_NONE,  C_NONE,  0, 0);

        // memory wait preempts LOAD_STALL; the remaining stall is abandoned
        do_reset();
        cyc("lp_c1", v_lu,   C_STALL, C_STALL, 0, 0);
        cyc("lp_c2", v_wait, C_FRZ,   C_FRZ,   0, 0);
        cyc("lp_c3", v_ack,  C_NONE,  C_NONE,  0, 0);
        cyc("lp_c4", v_idle, C_NONE,  C_NONE,  0, 0);

        // default timeout 255: error visible from wait cycle 256, sticky past ack
        do_reset();
        for (int k = 1; k <= 257; k++) begin
            set_in(v_wait);
            #3;
            chk("to_freeze_a", {3'b0, ctrl_a}, {3'b0, C_FRZ});
            if (k == 255) chk("to_err_before", {7'b0, ifa.mem_error}, 8'd0);
            if (k == 256) chk("to_err_at",     {7'b0, ifa.mem_error}, 8'd1);
            @(posedge clk); #1;
        end
        cyc("to_ack",  v_ack,  C_NONE, C_NONE, 1, 1);
        cyc("to_idle", v_idle, C_NONE, C_NONE, 1, 1);
        reset = 1'b1;
        cyc("to_in_rst", v_idle, C_NONE, C_NONE, 0, 0);
        reset = 1'b0;
        cyc("to_after_rst", v_idle, C_NONE, C_NONE, 0, 0);

        // reset in the middle of dut_b's LOAD_STALL, then a clean new stall
        do_reset();
        cyc("rm_c1", v_lu, C_STALL, C_STALL, 0, 0);
        reset = 1'b1;
        set_in(v_lu);
        #3;
        chk("rm_fwd_a", {6'b0, ifa.fwd_rs1}, 8'd0);
        chk("rm_fwd_b", {6'b0, ifb.fwd_rs1}, 8'd0);
        cyc("rm_c2", v_lu,   C_NONE,  C_NONE,  0, 0);
        reset = 1'b0;
        cyc("rm_c3", v_idle, C_NONE,  C_NONE,  0, 0);
        cyc("rm_c4", v_lu,   C_STALL, C_STALL, 0, 0);
        cyc("rm_c5", v_idle, C_NONE,  C_STALL, 0, 0);
        cyc("rm_c6", v_idle, C_NONE,  C_STALL, 0, 0);
        cyc("rm_c7", v_idle, C_NONE,  C_NONE,  0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
